lcd_sync_rx: RTL and testbench

LCD_SYNC_RX -- requirements
Module: lcd_sync_rx

---
 rtl/lcd_pkg.sv | 17 +
 rtl/edge_det.sv | 31 +++
 rtl/lcd_sync_rx.sv | 162 ++++++++++++++++
 tb/tb_lcd_sync_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: timing defaults shared by the lcd_sync generator and lcd_sync_rx,
// plus the receiver lock FSM state type.
// Ports: none (package).
package lcd_pkg;

  localparam int H_ACTIVE_DEF = 800;   // active pixels per line
  localparam int H_TOTAL_DEF  = 1056;  // pixel ticks per line
  localparam int V_ACTIVE_DEF = 480;   // active lines per frame
  localparam int V_TOTAL_DEF  = 525;   // lines per frame

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/edge_det.sv
// edge_det: one input register stage plus one enabled delay stage; reports
// rise/fall between them, qualified by en.
// Ports: clk, rst (async high), en (delay-stage enable), d -> rise, fall.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic smp;
  logic dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp <= 1'b0;
      dly <= 1'b0;
    end else begin
      smp <= d;
      // The delay stage only advances when enabled, so edges are measured
      // between successive enabled samples rather than successive clocks.
      if (en) dly <= smp;
    end
  end

  assign rise = en &  smp & ~dly;
  assign fall = en & ~smp &  dly;

endmodule

// File: rtl/lcd_sync_rx.sv
// lcd_sync_rx: receiving end of the lcd_sync interface. Recovers fila/columna
// from NCLK/HD/VD/DEN, measures line/frame length, reports lock and errors.
// Ports: CLK, RST (async high), NCLK/HD/VD/DEN in; pixel_valid, fila, columna,
// line_start, frame_start, h_meas, v_meas, lock, err_h, err_v out.
module lcd_sync_rx
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        NCLK,
  input  logic        HD,
  input  logic        VD,
  input  logic        DEN,
  output logic        pixel_valid,
  output logic [9:0]  fila,
  output logic [10:0] columna,
  output logic        line_start,
  output logic        frame_start,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic        lock,
  output logic        err_h,
  output logic        err_v
);

  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [10:0] COL_MAX   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  ROW_MAX   = 10'(V_ACTIVE - 1);

  logic        pix_tick, hd_fall, vd_fall;
  logic        nclk_fall_unused, hd_rise_unused, vd_rise_unused;
  logic        den_smp;
  logic        tick, hf, vf, de;
  logic [10:0] hcnt, col_cnt;
  logic [9:0]  vcnt, row_cnt;
  logic        col_full, line_den, herr_seen;
  logic [11:0] h_next;
  logic [10:0] v_next;
  logic        active, err_h_now, err_v_now;
  rx_state_t   state, state_nx;

  edge_det u_nclk (.clk(CLK), .rst(RST), .en(1'b1),     .d(NCLK),
                   .rise(pix_tick),       .fall(nclk_fall_unused));
  edge_det u_hd   (.clk(CLK), .rst(RST), .en(pix_tick), .d(HD),
                   .rise(hd_rise_unused), .fall(hd_fall));
  edge_det u_vd   (.clk(CLK), .rst(RST), .en(pix_tick), .d(VD),
                   .rise(vd_rise_unused), .fall(vd_fall));

  // Second pipeline stage: registering the tick-qualified events puts the
  // output pulses exactly two CLK edges after NCLK is first sampled high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      den_smp <= 1'b0;
      tick    <= 1'b0;
      hf      <= 1'b0;
      vf      <= 1'b0;
      de      <= 1'b0;
    end else begin
      den_smp <= DEN;
      tick    <= pix_tick;
      hf      <= hd_fall;
      vf      <= vd_fall;
      de      <= pix_tick & den_smp;
    end
  end

  assign h_next    = {1'b0, hcnt} + 12'd1;
  assign v_next    = {1'b0, vcnt} + 11'd1;
  assign active    = (state != SEARCH);
  // col_full marks that the last legal column was already emitted this line.
  assign err_h_now = active & ((hf & (h_next != H_TOTAL_W)) | (de & col_full));
  assign err_v_now = active & vf & (v_next != V_TOTAL_W);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pixel_valid <= 1'b0;
      fila        <= '0;
      columna     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      col_full    <= 1'b0;
      line_den    <= 1'b0;
      herr_seen   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      line_start  <= hf;
      frame_start <= vf;
      err_h       <= err_h_now;
      err_v       <= err_v_now;

      if (tick && hcnt != 11'h7FF) hcnt <= hcnt + 11'd1;
      if (hf) columna <= '0;
      if (vf) fila    <= '0;

      // Pixel reports the coordinates before this tick's increment.
      if (de) begin
        line_den    <= 1'b1;
        pixel_valid <= active;
        if (active) begin
          fila    <= row_cnt;
          columna <= col_cnt;
        end
        if (col_cnt == COL_MAX) col_full <= 1'b1;
        else                    col_cnt  <= col_cnt + 11'd1;
      end

      if (hf) begin
        h_meas   <= h_next[11] ? 11'h7FF : h_next[10:0];
        hcnt     <= '0;
        col_cnt  <= '0;
        col_full <= 1'b0;
        line_den <= 1'b0;
        if (line_den && row_cnt != ROW_MAX) row_cnt <= row_cnt + 10'd1;
        if (vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;
      end

      // Placed after the HD handling so a coincident VD fall wins.
      if (vf) begin
        v_meas  <= v_next[10] ? 10'h3FF : v_next[9:0];
        vcnt    <= '0;
        row_cnt <= '0;
      end

      if (vf)             herr_seen <= 1'b0;
      else if (err_h_now) herr_seen <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= SEARCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SEARCH:  if (vf) state_nx = MEASURE;
      MEASURE: if (vf && !err_v_now && !err_h_now && !herr_seen) state_nx = LOCKED;
      LOCKED:  if (err_h_now || err_v_now) state_nx = MEASURE;
      default: state_nx = SEARCH;
    endcase
  end

  always_comb begin
    lock = (state == LOCKED);
  end

endmodule

// File: tb/tb_lcd_sync_rx.sv
// tb_lcd_sync_rx: drives small-geometry lcd_sync timing frames into
// lcd_sync_rx and checks pixels, pulses, measurements and lock.
// Ports: none (bench top).
module tb_lcd_sync_rx;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 4;
  localparam int VT = 6;

  logic CLK = 1'b0, RST = 1'b1, NCLK = 1'b0, HD = 1'b1, VD = 1'b1, DEN = 1'b0;
  logic        pixel_valid, line_start, frame_start, lock, err_h, err_v;
  logic [9:0]  fila, v_meas;
  logic [10:0] columna, h_meas;

  lcd_sync_rx #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
    .CLK(CLK), .RST(RST), .NCLK(NCLK), .HD(HD), .VD(VD), .DEN(DEN),
    .pixel_valid(pixel_valid), .fila(fila), .columna(columna),
    .line_start(line_start), .frame_start(frame_start),
    .h_meas(h_meas), .v_meas(v_meas), .lock(lock), .err_h(err_h), .err_v(err_v)
  );

  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int fila; int col; int due; } pix_t;
  pix_t exp_q[$];

  typedef struct {
    int lines; int cut_line; int cut_len; int rst_line;
    int lock_start; int lock_end; int n_err_h; int n_err_v; int n_pix; int vmeas;
  } frame_vec_t;
  frame_vec_t tbl [11];

  int n_tests = 0, n_fail = 0;
  int ls_cnt, fs_cnt, eh_cnt, ev_cnt, pix_cnt, eh_locked, fs_cyc, exp_fs_cyc;
  int lock_start_s;
  logic fs_ls;
  logic armed = 1'b0, prev_vd = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (pixel_valid) begin
      pix_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pixel: fila=%0d columna=%0d cycle=%0d, expected no pixel",
                 fila, columna, cyc);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        chk("pixel_fila", fila, e.fila);
        chk("pixel_columna", columna, e.col);
        chk("pixel_latency", cyc, e.due);
      end
    end
    if (line_start) ls_cnt++;
    if (frame_start) begin
      fs_cnt++;
      fs_cyc = cyc;
      fs_ls  = line_start;
    end
    if (err_h) begin
      eh_cnt++;
      if (lock) eh_locked++;
    end
    if (err_v) ev_cnt++;
  end

  task automatic clear_counts();
    ls_cnt = 0; fs_cnt = 0; eh_cnt = 0; ev_cnt = 0; pix_cnt = 0; eh_locked = 0;
    fs_cyc = -1; fs_ls = 1'b0;
  endtask

  // One pixel tick: data changes while NCLK is low, NCLK rises a cycle later.
  task automatic drive_tick(input logic hd, input logic vd, input logic den,
                            input int f, input int c);
    @(negedge CLK);
    NCLK = 1'b0; HD = hd; VD = vd; DEN = den;
    @(negedge CLK);
    NCLK = 1'b1;
    if (prev_vd && !vd) begin
      armed      = 1'b1;
      exp_fs_cyc = cyc + 3;
    end
    prev_vd = vd;
    if (den && armed) exp_q.push_back('{f, c, cyc + 3});
  endtask

  task automatic mid_reset();
    @(negedge CLK);
    #1 RST = 1'b1;
    exp_q.delete();
    armed   = 1'b0;
    prev_vd = 1'b0;
    @(negedge CLK);
    chk("midrst_outputs",
        {pixel_valid, fila, columna, line_start, frame_start, h_meas, v_meas, err_h, err_v}, 0);
    chk("midrst_lock", lock, 0);
    @(negedge CLK);
    #1 RST = 1'b0;
  endtask

  // HD low for ticks 0-1, DEN on ticks 2..2+HA-1 of lines 1..VA, VD low on line 0.
  task automatic run_frame(input frame_vec_t fv);
    clear_counts();
    for (int v = 0; v < fv.lines; v++) begin
      int len;
      len = (v == fv.cut_line) ? fv.cut_len : HT;
      for (int h = 0; h < len; h++) begin
        logic den;
        if (v == fv.rst_line && h == 5) mid_reset();
        den = (v >= 1 && v <= VA && h >= 2 && h < 2 + HA);
        drive_tick(h >= 2, v != 0, den, v - 1, h - 2);
        if (v == 0 && h == 3) lock_start_s = lock;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // lines, cut_line, cut_len, rst_line, lock_start, lock_end, err_h, err_v, pixels, v_meas
    tbl[0]  = '{6, -1,  0, -1, 0, 0, 0, 0, 32, -1};
    tbl[1]  = '{6, -1,  0, -1, 1, 1, 0, 0, 32,  6};
    tbl[2]  = '{6,  2, 10, -1, 1, 0, 1, 0, 32,  6};
    tbl[3]  = '{6, -1,  0, -1, 0, 0, 0, 0, 32,  6};
    tbl[4]  = '{6, -1,  0, -1, 1, 1, 0, 0, 32,  6};
    tbl[5]  = '{7, -1,  0, -1, 1, 1, 0, 0, 32,  6};
    tbl[6]  = '{6, -1,  0, -1, 0, 0, 0, 1, 32,  7};
    tbl[7]  = '{6, -1,  0, -1, 1, 1, 0, 0, 32,  6};
    tbl[8]  = '{6, -1,  0,  2, 1, 0, 0, 0, -1,  0};
    tbl[9]  = '{6, -1,  0, -1, 0, 0, 0, 0, 32,  4};
    tbl[10] = '{6, -1,  0, -1, 1, 1, 0, 0, 32,  6};

    clear_counts();
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("reset_outputs",
        {pixel_valid, fila, columna, line_start, frame_start, h_meas, v_meas, err_h, err_v}, 0);
    chk("reset_lock", lock, 0);
    #1 RST = 1'b0;

    // DEN toggling before any VD fall must not produce pixels or errors.
    repeat (12) drive_tick(1'b1, 1'b1, 1'b1, 0, 0);
    repeat (2)  drive_tick(1'b1, 1'b1, 1'b0, 0, 0);
    repeat (4)  @(negedge CLK);
    chk("pre_vd_pixels", pix_cnt, 0);
    chk("pre_vd_err_h", eh_cnt, 0);
    chk("pre_vd_lock", lock, 0);

    for (int k = 0; k < 11; k++) begin
      run_frame(tbl[k]);
      chk($sformatf("f%0d_lock_start", k), lock_start_s, tbl[k].lock_start);
      chk($sformatf("f%0d_lock_end", k), lock, tbl[k].lock_end);
      chk($sformatf("f%0d_line_starts", k), ls_cnt, tbl[k].lines);
      chk($sformatf("f%0d_frame_starts", k), fs_cnt, 1);
      chk($sformatf("f%0d_err_h", k), eh_cnt, tbl[k].n_err_h);
      chk($sformatf("f%0d_err_v", k), ev_cnt, tbl[k].n_err_v);
      chk($sformatf("f%0d_err_h_with_lock", k), eh_locked, 0);
      chk($sformatf("f%0d_fs_latency", k), fs_cyc, exp_fs_cyc);
      chk($sformatf("f%0d_fs_with_ls", k), fs_ls, 1);
      chk($sformatf("f%0d_h_meas", k), h_meas, HT);
      chk($sformatf("f%0d_pix_pending", k), exp_q.size(), 0);
      if (tbl[k].n_pix >= 0) chk($sformatf("f%0d_pixels", k), pix_cnt, tbl[k].n_pix);
      if (tbl[k].vmeas >= 0) chk($sformatf("f%0d_v_meas", k), v_meas, tbl[k].vmeas);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
